// File: rtl/coin_ctrl_pkg.sv
// coin_ctrl_pkg: shared state encoding and coin weights for the credit controller
package coin_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DISPENSE, CHG_PAY, CHG_GAP} state_t;
  localparam int COIN_HALF_W = 1;
  localparam int COIN_ONE_W  = 2;
  localparam int COIN_FIVE_W = 10;
endpackage

// File: rtl/coin_ctrl_change_pay.sv
// coin_ctrl_change_pay: picks the next change coin and its decrement from the remaining credit
module coin_ctrl_change_pay #(
  parameter int SUM_W = 6
) (
  input  logic [SUM_W-1:0] credit_i,
  output logic             one_o,
  output logic             half_o,
  output logic [SUM_W-1:0] dec_o
);
  always_comb begin
    one_o  = credit_i >= SUM_W'(2);
    half_o = !one_o && credit_i != '0;
    dec_o  = one_o ? SUM_W'(2) : SUM_W'(half_o);
  end
endmodule

// File: rtl/coin_ctrl.sv
// coin_ctrl: vending credit controller; accepts coins, dispenses on buy, pays change on cancel
module coin_ctrl
  import coin_ctrl_pkg::*;
#(
  parameter int SUM_W    = 6,
  parameter int MAX_SUM  = 63,
  parameter int DISP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_half,
  input  logic             coin_one,
  input  logic             coin_five,
  input  logic [SUM_W-1:0] price,
  input  logic             buy,
  input  logic             cancel,
  output logic [SUM_W-1:0] coin_sum,
  output logic             coin_reject,
  output logic             no_credit,
  output logic             dispense,
  output logic             change_one,
  output logic             change_half,
  output logic             busy
);
  localparam int CNT_W = DISP_CYC > 1 ? $clog2(DISP_CYC) : 1;
  state_t           state_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             reject_q, no_credit_q, disp_q, ch_one_q, ch_half_q;
  logic [SUM_W:0]   inc, sum_inc;
  logic             any_coin, over;
  logic             pay_one, pay_half;
  logic [SUM_W-1:0] pay_dec;
  coin_ctrl_change_pay #(.SUM_W(SUM_W)) u_change_pay (
    .credit_i (sum_q),
    .one_o    (pay_one),
    .half_o   (pay_half),
    .dec_o    (pay_dec)
  );
  // sum is formed one bit wider so an overflowing insert is caught instead of wrapping
  always_comb begin
    inc      = (coin_half ? (SUM_W+1)'(COIN_HALF_W) : '0)
             + (coin_one  ? (SUM_W+1)'(COIN_ONE_W)  : '0)
             + (coin_five ? (SUM_W+1)'(COIN_FIVE_W) : '0);
    sum_inc  = {1'b0, sum_q} + inc;
    over     = sum_inc > (SUM_W+1)'(MAX_SUM);
    any_coin = coin_half | coin_one | coin_five;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      reject_q    <= 1'b0;
      no_credit_q <= 1'b0;
      disp_q      <= 1'b0;
      ch_one_q    <= 1'b0;
      ch_half_q   <= 1'b0;
    end else begin
      reject_q    <= any_coin;
      no_credit_q <= 1'b0;
      ch_one_q    <= 1'b0;
      ch_half_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          reject_q <= any_coin & (buy | cancel | over);
          if (cancel) begin
            if (sum_q != '0) state_q <= CHG_PAY;
          end else if (buy) begin
            if (price != '0 && price <= sum_q) begin
              sum_q   <= sum_q - price;
              disp_q  <= 1'b1;
              cnt_q   <= CNT_W'(DISP_CYC - 1);
              state_q <= DISPENSE;
            end else if (price != '0) begin
              no_credit_q <= 1'b1;
            end
          end else if (!over) begin
            sum_q <= sum_inc[SUM_W-1:0];
          end
        end
        DISPENSE: begin
          if (cnt_q == '0) begin
            disp_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CHG_PAY: begin
          ch_one_q  <= pay_one;
          ch_half_q <= pay_half;
          sum_q     <= sum_q - pay_dec;
          state_q   <= CHG_GAP;
        end
        CHG_GAP: state_q <= sum_q != '0 ? CHG_PAY : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign coin_sum    = sum_q;
  assign coin_reject = reject_q;
  assign no_credit   = no_credit_q;
  assign dispense    = disp_q;
  assign change_one  = ch_one_q;
  assign change_half = ch_half_q;
  assign busy        = state_q != IDLE;
endmodule
